// File: rtl/stack_pkg.sv
// Shared types and helpers for the dual-issue stack: per-slot operation
// decode used by the top-level accept logic.
package stack_pkg;

    // Operation requested by one instruction slot in a given cycle.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_ILL  = 2'd3
    } slot_op_t;

    // Map a slot's raw push/pop request pair onto an operation.
    // Asking for push and pop on the same slot is malformed and reported as OP_ILL.
    function automatic slot_op_t decode_slot(input logic push, input logic pop);
        slot_op_t op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_ILL;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage : stack_pkg

// File: rtl/stack_ram_2w2r.sv
// Stack storage: DEPTH x WIDTH flop array with two write ports and two
// synchronous read ports. Reads return the contents from before any
// same-edge write. When both write ports hit the same address, port 1 wins.
module stack_ram_2w2r #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int RA    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we0,
    input  logic [RA-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1,
    input  logic [RA-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             re0,
    input  logic [RA-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             re1,
    input  logic [RA-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage writes; port 1 is written last so it wins on an address clash.
    // NOTE: the array has no reset on purpose -- a stack never reads a slot it has
    // not written, and leaving the array out of the reset tree lets it map onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    // Registered read ports. They hold their value when no read is enabled.
    // NOTE: non-blocking assignments make these reads sample the array
    // before this edge's writes land. That is the read-before-write behaviour the stack relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (re0) begin
                rdata0 <= mem[raddr0];
            end
            if (re1) begin
                rdata1 <= mem[raddr1];
            end
        end
    end

endmodule : stack_ram_2w2r

// File: rtl/stack_2slot.sv
// Dual-issue hardware stack serving push/pop from two in-order instruction
// slots per cycle. Slot 0 (older) is resolved against the current stack
// pointer. Slot 1 (younger) is resolved against the pointer after slot 0's effect.
// Pop data is registered and goes to the EX/DM boundary.
module stack_2slot
    import stack_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             clr_err,
    input  logic             push0,
    input  logic             pop0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             push1,
    input  logic             pop1,
    input  logic [WIDTH-1:0] wdata1,
    output logic [WIDTH-1:0] rdata0,
    output logic             rvalid0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid1,
    output logic             acc0,
    output logic             acc1,
    output logic [AW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf,
    output logic             ill
);

    localparam int          RA       = AW - 1;
    localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);

    // Stack pointer, which is also the occupancy. mem[sp-1] is the top of stack.
    logic [AW-1:0]    sp;
    logic [AW-1:0]    sp_mid;
    logic [AW-1:0]    sp_nxt;

    slot_op_t         op0;
    slot_op_t         op1;

    // Slot 0 pushes and slot 1 pops the same value in one cycle: it is forwarded without a storage access.
    logic             fwd;

    logic             we0;
    logic             we1;
    logic [RA-1:0]    waddr0;
    logic [RA-1:0]    waddr1;
    logic             re0;
    logic             re1;
    logic [RA-1:0]    raddr0;
    logic [RA-1:0]    raddr1;

    logic             ovf_set;
    logic             udf_set;
    logic             ill_set;

    logic [WIDTH-1:0] ram_rdata0;
    logic [WIDTH-1:0] ram_rdata1;

    // Slot 1 result source: the forward register when the last slot-1 pop was forwarded.
    logic [WIDTH-1:0] fwd_q;
    logic             sel_fwd_q;

    // Decode both slots, decide acceptance in program order, and derive the storage accesses and next pointer.
    // NOTE: every output of this block gets a default before any branch,
    // so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        op0     = decode_slot(push0, pop0);
        op1     = decode_slot(push1, pop1);
        fwd     = 1'b0;
        acc0    = 1'b0;
        acc1    = 1'b0;
        we0     = 1'b0;
        we1     = 1'b0;
        re0     = 1'b0;
        re1     = 1'b0;
        sp_mid  = sp;
        sp_nxt  = sp;
        waddr0  = sp[RA-1:0];
        waddr1  = sp[RA-1:0];
        raddr0  = RA'(sp - AW'(1));
        raddr1  = RA'(sp - AW'(1));
        ovf_set = 1'b0;
        udf_set = 1'b0;
        ill_set = 1'b0;

        if (flush) begin
            sp_nxt = '0;
        end else begin
            ill_set = (op0 == OP_ILL) || (op1 == OP_ILL);

            if ((op0 == OP_PUSH) && (op1 == OP_POP)) begin
                // The pushed value is consumed at once, so the pair always succeeds, even on a full stack.
                fwd  = 1'b1;
                acc0 = 1'b1;
                acc1 = 1'b1;
            end else begin
                // Slot 0 is resolved against the current pointer.
                case (op0)
                    OP_PUSH: begin
                        if (sp != DEPTH_AW) begin
                            acc0   = 1'b1;
                            we0    = 1'b1;
                            waddr0 = sp[RA-1:0];
                            sp_mid = sp + AW'(1);
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (sp != '0) begin
                            acc0   = 1'b1;
                            re0    = 1'b1;
                            raddr0 = RA'(sp - AW'(1));
                            sp_mid = sp - AW'(1);
                        end else begin
                            udf_set = 1'b1;
                        end
                    end
                    default: ;
                endcase

                // Slot 1 is resolved against the pointer after slot 0's effect.
                sp_nxt = sp_mid;
                case (op1)
                    OP_PUSH: begin
                        if (sp_mid != DEPTH_AW) begin
                            acc1   = 1'b1;
                            we1    = 1'b1;
                            waddr1 = sp_mid[RA-1:0];
                            sp_nxt = sp_mid + AW'(1);
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (sp_mid != '0) begin
                            acc1   = 1'b1;
                            re1    = 1'b1;
                            raddr1 = RA'(sp_mid - AW'(1));
                            sp_nxt = sp_mid - AW'(1);
                        end else begin
                            udf_set = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    stack_ram_2w2r #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .re0    (re0),
        .raddr0 (raddr0),
        .rdata0 (ram_rdata0),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (ram_rdata1)
    );

    // Pointer, result-valid pulses, forward path and sticky error flags.
    // A new error in the same cycle wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            fwd_q     <= '0;
            sel_fwd_q <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            ill       <= 1'b0;
        end else begin
            sp      <= sp_nxt;
            rvalid0 <= re0;
            rvalid1 <= re1 | fwd;
            if (fwd) begin
                fwd_q     <= wdata0;
                sel_fwd_q <= 1'b1;
            end else if (re1) begin
                sel_fwd_q <= 1'b0;
            end
            ovf <= ovf_set | (ovf & ~clr_err);
            udf <= udf_set | (udf & ~clr_err);
            ill <= ill_set | (ill & ~clr_err);
        end
    end

    assign rdata0 = ram_rdata0;
    assign rdata1 = sel_fwd_q ? fwd_q : ram_rdata1;
    assign count  = sp;
    assign full   = (sp == DEPTH_AW);
    assign empty  = (sp == '0);

endmodule : stack_2slot

// File: tb/tb_stack_2slot.sv
// Self-checking bench for stack_2slot (WIDTH=16, DEPTH=4). A queue-based
// reference stack predicts acceptance, occupancy, pop data and the sticky
// flags. Every cycle the DUT is compared against it, and literal values pin the reference itself.
module tb_stack_2slot;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             clr_err;
    logic             push0;
    logic             pop0;
    logic [WIDTH-1:0] wdata0;
    logic             push1;
    logic             pop1;
    logic [WIDTH-1:0] wdata1;
    logic [WIDTH-1:0] rdata0;
    logic             rvalid0;
    logic [WIDTH-1:0] rdata1;
    logic             rvalid1;
    logic             acc0;
    logic             acc1;
    logic [AW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             udf;
    logic             ill;

    int n_total = 0;
    int n_pass  = 0;

    stack_2slot #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .clr_err (clr_err),
        .push0   (push0),
        .pop0    (pop0),
        .wdata0  (wdata0),
        .push1   (push1),
        .pop1    (pop1),
        .wdata1  (wdata1),
        .rdata0  (rdata0),
        .rvalid0 (rvalid0),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1),
        .acc0    (acc0),
        .acc1    (acc1),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .udf     (udf),
        .ill     (ill)
    );

    always #5 clk = ~clk;

    // Reference state: the stack itself (back = top), last results and flags.
    logic [WIDTH-1:0] m_stk[$];
    logic [WIDTH-1:0] m_rd0;
    logic [WIDTH-1:0] m_rd1;
    logic             m_rv0;
    logic             m_rv1;
    logic             m_ovf;
    logic             m_udf;
    logic             m_ill;
    logic             obs_a0;
    logic             obs_a1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 idle, 1 push, 2 pop, 3 both (malformed)
    function automatic int kind(input logic p, input logic q);
        if (p && q) return 3;
        if (p)      return 1;
        if (q)      return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_rd0 = '0;
        m_rd1 = '0;
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_ill = 1'b0;
    endtask

    // Which slots succeed, judged from occupancy in program order.
    task automatic model_acc(input logic f, input logic p0, input logic q0,
                             input logic p1, input logic q1,
                             output logic a0, output logic a1);
        int k0;
        int k1;
        int n;
        k0 = kind(p0, q0);
        k1 = kind(p1, q1);
        n  = m_stk.size();
        a0 = 1'b0;
        a1 = 1'b0;
        if (!f) begin
            if (k0 == 1 && k1 == 2) begin
                a0 = 1'b1;
                a1 = 1'b1;
            end else begin
                if (k0 == 1 && n < DEPTH) begin
                    a0 = 1'b1;
                    n++;
                end else if (k0 == 2 && n > 0) begin
                    a0 = 1'b1;
                    n--;
                end
                if ((k1 == 1 && n < DEPTH) || (k1 == 2 && n > 0)) a1 = 1'b1;
            end
        end
    endtask

    // Advance the reference by one clock edge.
    task automatic model_step(input logic f, input logic c,
                              input logic p0, input logic q0, input logic [WIDTH-1:0] w0,
                              input logic p1, input logic q1, input logic [WIDTH-1:0] w1);
        logic a0;
        logic a1;
        logic no;
        logic nu;
        logic ni;
        int   k0;
        int   k1;
        model_acc(f, p0, q0, p1, q1, a0, a1);
        k0 = kind(p0, q0);
        k1 = kind(p1, q1);
        no = 1'b0;
        nu = 1'b0;
        ni = 1'b0;
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        if (f) begin
            m_stk.delete();
        end else begin
            ni = (k0 == 3) || (k1 == 3);
            no = (k0 == 1 && !a0) || (k1 == 1 && !a1);
            nu = (k0 == 2 && !a0) || (k1 == 2 && !a1);
            if (k0 == 1 && k1 == 2) begin
                m_rd1 = w0;
                m_rv1 = 1'b1;
            end else begin
                if (a0 && k0 == 1) m_stk.push_back(w0);
                if (a0 && k0 == 2) begin
                    m_rd0 = m_stk.pop_back();
                    m_rv0 = 1'b1;
                end
                if (a1 && k1 == 1) m_stk.push_back(w1);
                if (a1 && k1 == 2) begin
                    m_rd1 = m_stk.pop_back();
                    m_rv1 = 1'b1;
                end
            end
        end
        m_ovf = no | (m_ovf & ~c);
        m_udf = nu | (m_udf & ~c);
        m_ill = ni | (m_ill & ~c);
    endtask

    task automatic check_state();
        check("count",   32'(count),   32'(m_stk.size()));
        check("full",    32'(full),    32'(m_stk.size() == DEPTH));
        check("empty",   32'(empty),   32'(m_stk.size() == 0));
        check("rvalid0", 32'(rvalid0), 32'(m_rv0));
        check("rvalid1", 32'(rvalid1), 32'(m_rv1));
        check("rdata0",  32'(rdata0),  32'(m_rd0));
        check("rdata1",  32'(rdata1),  32'(m_rd1));
        check("ovf",     32'(ovf),     32'(m_ovf));
        check("udf",     32'(udf),     32'(m_udf));
        check("ill",     32'(ill),     32'(m_ill));
    endtask

    // One clock: drive at the falling edge, check accept just before the
    // rising edge, step the reference, then check registered state at the next falling edge.
    task automatic cyc(input logic f, input logic c,
                       input logic p0, input logic q0, input logic [WIDTH-1:0] w0,
                       input logic p1, input logic q1, input logic [WIDTH-1:0] w1);
        logic ea0;
        logic ea1;
        flush   = f;
        clr_err = c;
        push0   = p0;
        pop0    = q0;
        wdata0  = w0;
        push1   = p1;
        pop1    = q1;
        wdata1  = w1;
        #1;
        model_acc(f, p0, q0, p1, q1, ea0, ea1);
        obs_a0 = acc0;
        obs_a1 = acc1;
        check("acc0", 32'(acc0), 32'(ea0));
        check("acc1", 32'(acc1), 32'(ea1));
        @(posedge clk);
        model_step(f, c, p0, q0, w0, p1, q1, w1);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();                         cyc(0, 0, 0, 0, '0, 0, 0, '0); endtask
    task automatic clr();                          cyc(0, 1, 0, 0, '0, 0, 0, '0); endtask
    task automatic push_0(input logic [WIDTH-1:0] w); cyc(0, 0, 1, 0, w, 0, 0, '0); endtask
    task automatic pop_0();                        cyc(0, 0, 0, 1, '0, 0, 0, '0); endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; clr_err = 1'b0;
        push0 = 1'b0; pop0 = 1'b0; wdata0 = '0;
        push1 = 1'b0; pop1 = 1'b0; wdata1 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count",   32'(count),   32'd0);
        check("rst_empty",   32'(empty),   32'd1);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rdata1",  32'(rdata1),  32'd0);
        check("rst_ovf",     32'(ovf),     32'd0);
        rst = 1'b0;

        // LIFO order through slot 0
        push_0(16'hA); push_0(16'hB); push_0(16'hC);
        check("lit_count3", 32'(count), 32'd3);
        pop_0();
        check("lit_pop_c",  32'(rdata0),  32'hC);
        check("lit_rv0",    32'(rvalid0), 32'd1);
        pop_0();
        check("lit_pop_b",  32'(rdata0),  32'hB);
        pop_0();
        check("lit_pop_a",  32'(rdata0),  32'hA);
        check("lit_empty",  32'(empty),   32'd1);
        idle();
        check("lit_rv0_off", 32'(rvalid0), 32'd0);

        // Dual push then dual pop
        cyc(0, 0, 1, 0, 16'h11, 1, 0, 16'h22);
        check("lit_count2", 32'(count), 32'd2);
        cyc(0, 0, 0, 1, '0, 0, 1, '0);
        check("lit_dpop0", 32'(rdata0), 32'h22);
        check("lit_dpop1", 32'(rdata1), 32'h11);
        check("lit_count0", 32'(count), 32'd0);

        // Overflow on the last free slot
        push_0(16'h1); push_0(16'h2); push_0(16'h3);
        cyc(0, 0, 1, 0, 16'h4, 1, 0, 16'h5);
        check("lit_ovf_a0", 32'(obs_a0), 32'd1);
        check("lit_ovf_a1", 32'(obs_a1), 32'd0);
        check("lit_full",   32'(full),   32'd1);
        check("lit_ovf",    32'(ovf),    32'd1);
        clr();
        check("lit_ovf_clr", 32'(ovf), 32'd0);

        // Forward on a full stack
        cyc(0, 0, 1, 0, 16'h55, 0, 1, '0);
        check("lit_fwd",    32'(rdata1),  32'h55);
        check("lit_fwd_rv", 32'(rvalid1), 32'd1);
        check("lit_fwd_n",  32'(count),   32'd4);

        // Pop-then-push replaces the top (read before write)
        pop_0();
        push_0(16'h7);
        cyc(0, 0, 0, 1, '0, 1, 0, 16'h9);
        check("lit_swap_rd", 32'(rdata0), 32'h7);
        check("lit_swap_n",  32'(count),  32'd4);
        pop_0();
        check("lit_swap_top", 32'(rdata0), 32'h9);

        // Malformed request, flush keeps the flag, clear drops it
        cyc(0, 0, 1, 1, 16'hEE, 0, 0, '0);
        check("lit_ill",   32'(ill),   32'd1);
        check("lit_ill_n", 32'(count), 32'd3);
        cyc(1, 0, 0, 0, '0, 0, 0, '0);
        check("lit_flush_n",   32'(count), 32'd0);
        check("lit_flush_ill", 32'(ill),   32'd1);
        clr();

        // Underflow on empty and with one entry
        cyc(0, 0, 0, 1, '0, 0, 1, '0);
        check("lit_udf",     32'(udf),     32'd1);
        check("lit_udf_rv0", 32'(rvalid0), 32'd0);
        check("lit_udf_rv1", 32'(rvalid1), 32'd0);
        clr();
        push_0(16'h66);
        cyc(0, 0, 0, 1, '0, 0, 1, '0);
        check("lit_one_rd",  32'(rdata0), 32'h66);
        check("lit_one_a1",  32'(obs_a1), 32'd0);
        check("lit_one_udf", 32'(udf),    32'd1);
        check("lit_hold1",   32'(rdata1), 32'h55);
        clr();

        // Pop0 on empty with push1: push still happens
        cyc(0, 0, 0, 1, '0, 1, 0, 16'h77);
        check("lit_e_a0", 32'(obs_a0), 32'd0);
        check("lit_e_a1", 32'(obs_a1), 32'd1);
        check("lit_e_n",  32'(count),  32'd1);
        cyc(0, 1, 0, 0, '0, 0, 1, '0);
        check("lit_e_pop1", 32'(rdata1), 32'h77);

        // Mixed traffic against the reference
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), WIDTH'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), WIDTH'($urandom));
        end

        // Asynchronous reset mid-stream
        push_0(16'h31);
        cyc(0, 0, 1, 0, 16'h32, 0, 1, '0);
        cyc(0, 0, 1, 1, '0, 0, 1, '0);
        rst = 1'b1;
        #1;
        check("arst_count",   32'(count),   32'd0);
        check("arst_rdata0",  32'(rdata0),  32'd0);
        check("arst_rdata1",  32'(rdata1),  32'd0);
        check("arst_rvalid0", 32'(rvalid0), 32'd0);
        check("arst_rvalid1", 32'(rvalid1), 32'd0);
        check("arst_flags",   32'({ovf, udf, ill}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        push_0(16'h44);
        pop_0();
        check("lit_post_rst", 32'(rdata0), 32'h44);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_stack_2slot
